// File: rtl/booth_mac_pkg.sv
// Shared types and constants for the Booth multiplier MAC sequencer.
package booth_mac_pkg;

  localparam int unsigned DefAccW     = 24;
  localparam int unsigned DefDrainCyc = 20;
  localparam int unsigned ProdW       = 16;
  localparam int unsigned OpW         = 8;

  typedef enum logic [2:0] {
    StDrain,
    StIdle,
    StIssue,
    StWaitClr,
    StWaitDone,
    StAccum,
    StOut
  } state_e;

endpackage

// File: rtl/booth_mac_acc.sv
// Accumulate step: sign-extend the 16-bit product, add it to the running sum and flag
// signed overflow. Build with BOOTH_MAC_SAT_EN defined to clamp on overflow instead of
// wrapping.
module booth_mac_acc
  import booth_mac_pkg::*;
#(
  parameter int unsigned ACC_W = DefAccW
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ProdW-1:0] product,
  output logic [ACC_W-1:0] next_acc,
  output logic             ovf_hit
);

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;

  // Sign-extend, add, and detect overflow as equal operand signs with a differing sum sign.
  always_comb begin
    ext     = {{(ACC_W - ProdW){product[ProdW-1]}}, product};
    sum     = acc + ext;
    ovf_hit = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

`ifdef BOOTH_MAC_SAT_EN
  // Clamp toward the overflow direction; both operands share the sign of acc.
  always_comb begin
    next_acc = sum;
    if (ovf_hit) begin
      next_acc = acc[ACC_W-1] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end
  end
`else
  // Plain two's-complement wrap.
  always_comb begin
    next_acc = sum;
  end
`endif

endmodule

// File: rtl/booth_mac_ctrl.sv
// Sequencer and dot-product accumulator wrapped around an external 8x8 signed Booth
// multiplier (St/Done handshake). Optional saturation is enabled with BOOTH_MAC_SAT_EN.
module booth_mac_ctrl
  import booth_mac_pkg::*;
#(
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned DRAIN_CYC = DefDrainCyc
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [OpW-1:0]   In_A,
  input  logic [OpW-1:0]   In_B,
  input  logic             In_Last,
  output logic             Mul_St,
  output logic [OpW-1:0]   Mul_Mplier,
  output logic [OpW-1:0]   Mul_Mcand,
  input  logic [ProdW-1:0] Mul_Product,
  input  logic             Mul_Done,
  output logic [ACC_W-1:0] Acc_Out,
  output logic             Acc_Valid,
  output logic             Ovf
);

  localparam int unsigned CntW = $clog2(DRAIN_CYC + 1);

  state_e           state_q;
  logic [CntW-1:0]  drain_cnt_q;
  logic             in_ready_q;
  logic             mul_st_q;
  logic [OpW-1:0]   mplier_q;
  logic [OpW-1:0]   mcand_q;
  logic             last_q;
  logic             first_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_out_q;
  logic             acc_valid_q;
  logic             ovf_q;

  logic [ACC_W-1:0] next_acc;
  logic             ovf_hit;

  booth_mac_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .acc      (acc_q),
    .product  (Mul_Product),
    .next_acc (next_acc),
    .ovf_hit  (ovf_hit)
  );

  // Control FSM with registered outputs; the multiplier has no reset, so DRAIN waits out
  // any operation it may still be running and ignores its Done.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StDrain;
      drain_cnt_q <= '0;
      in_ready_q  <= 1'b0;
      mul_st_q    <= 1'b0;
      mplier_q    <= '0;
      mcand_q     <= '0;
      last_q      <= 1'b0;
      first_q     <= 1'b1;
      acc_q       <= '0;
      acc_out_q   <= '0;
      acc_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      mul_st_q    <= 1'b0;
      acc_valid_q <= 1'b0;
      unique case (state_q)
        StDrain: begin
          if (drain_cnt_q == CntW'(DRAIN_CYC - 1)) begin
            state_q    <= StIdle;
            in_ready_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        StIdle: begin
          if (In_Valid && in_ready_q) begin
            mplier_q   <= In_A;
            mcand_q    <= In_B;
            last_q     <= In_Last;
            in_ready_q <= 1'b0;
            mul_st_q   <= 1'b1;
            state_q    <= StIssue;
            if (first_q) begin
              acc_q   <= '0;
              ovf_q   <= 1'b0;
              first_q <= 1'b0;
            end
          end
        end
        StIssue: begin
          state_q <= StWaitClr;
        end
        // Done may still be high from the previous product until the St edge clears it.
        StWaitClr: begin
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (Mul_Done) begin
            state_q <= StAccum;
          end
        end
        StAccum: begin
          acc_q <= next_acc;
          ovf_q <= ovf_q | ovf_hit;
          if (last_q) begin
            acc_out_q   <= next_acc;
            acc_valid_q <= 1'b1;
            state_q     <= StOut;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= StIdle;
          end
        end
        StOut: begin
          first_q    <= 1'b1;
          in_ready_q <= 1'b1;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StDrain;
        end
      endcase
    end
  end

  assign In_Ready   = in_ready_q;
  assign Mul_St     = mul_st_q;
  assign Mul_Mplier = mplier_q;
  assign Mul_Mcand  = mcand_q;
  assign Acc_Out    = acc_out_q;
  assign Acc_Valid  = acc_valid_q;
  assign Ovf        = ovf_q;

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Scoreboard bench for booth_mac_ctrl with a behavioural Booth multiplier beside it.
module tb_booth_mac_ctrl;

  localparam int    AccW  = 24;
  localparam longint MaxV = 64'sd8388607;
  localparam longint MinV = -64'sd8388608;
  localparam longint Span = 64'sd16777216;

  typedef struct {
    int a;
    int b;
  } pair_t;

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  logic            Clk;
  logic            Rst;
  logic            In_Valid;
  logic            In_Ready;
  logic [7:0]      In_A;
  logic [7:0]      In_B;
  logic            In_Last;
  logic            Mul_St;
  logic [7:0]      Mul_Mplier;
  logic [7:0]      Mul_Mcand;
  logic [15:0]     Mul_Product;
  logic            Mul_Done;
  logic [AccW-1:0] Acc_Out;
  logic            Acc_Valid;
  logic            Ovf;

  booth_mac_ctrl #(
    .ACC_W     (AccW),
    .DRAIN_CYC (20)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .In_A        (In_A),
    .In_B        (In_B),
    .In_Last     (In_Last),
    .Mul_St      (Mul_St),
    .Mul_Mplier  (Mul_Mplier),
    .Mul_Mcand   (Mul_Mcand),
    .Mul_Product (Mul_Product),
    .Mul_Done    (Mul_Done),
    .Acc_Out     (Acc_Out),
    .Acc_Valid   (Acc_Valid),
    .Ovf         (Ovf)
  );

  int checks;
  int failures;
  int hs_count;
  int st_pulses;
  int mcand_err;

  exp_t  exp_q[$];
  pair_t pkt[$];

  // Behavioural multiplier: samples Mplier on St, reads Mcand at completion, keeps the
  // old Product and a stale Done=1 until the next St.
  logic signed [7:0] m_a;
  logic [7:0]        m_b;
  logic              m_busy;
  logic              m_orphan;
  int                m_cnt;
  logic              m_done;
  logic [15:0]       m_prod;

  assign Mul_Done    = m_done;
  assign Mul_Product = m_prod;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    m_done    = 1'b1;
    m_busy    = 1'b0;
    m_orphan  = 1'b0;
    m_cnt     = 0;
    m_prod    = 16'h1234;
    m_a       = '0;
    m_b       = '0;
    st_pulses = 0;
  end

  always @(posedge Clk) begin
    if (Rst) m_orphan <= 1'b1;
    if (Mul_St) begin
      m_done    <= 1'b0;
      m_busy    <= 1'b1;
      m_orphan  <= 1'b0;
      m_cnt     <= int'($urandom_range(17, 9));
      m_a       <= $signed(Mul_Mplier);
      m_b       <= Mul_Mcand;
      st_pulses <= st_pulses + 1;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
        m_prod <= 16'(int'(m_a) * int'($signed(Mul_Mcand)));
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every Acc_Valid and watches pulse widths.
  initial begin
    bit prev_valid;
    bit prev_st;
    exp_t e;
    prev_valid = 1'b0;
    prev_st    = 1'b0;
    mcand_err  = 0;
    forever begin
      @(posedge Clk);
      #1;
      if (Rst) begin
        prev_valid = 1'b0;
        prev_st    = 1'b0;
      end else begin
        if (Acc_Valid) begin
          if (prev_valid) chk("acc_valid_one_cycle", 1, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_acc_valid", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("acc_out", longint'($signed(Acc_Out)), e.acc);
            chk("ovf", longint'(Ovf), longint'(e.ovf));
          end
        end
        if (Mul_St && prev_st) chk("mul_st_one_cycle", 1, 0);
        if (m_busy && !m_orphan && Mul_Mcand !== m_b) mcand_err++;
        prev_valid = Acc_Valid;
        prev_st    = Mul_St;
      end
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    Rst      = 1'b1;
    In_Valid = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst_mul_st", longint'(Mul_St), 0);
    chk("rst_acc_valid", longint'(Acc_Valid), 0);
    @(posedge Clk);
    #1;
    chk("rst_in_ready", longint'(In_Ready), 0);
    chk("rst_acc_out", longint'(Acc_Out), 0);
    chk("rst_ovf", longint'(Ovf), 0);
    chk("rst_mplier", longint'(Mul_Mplier), 0);
    chk("rst_mcand", longint'(Mul_Mcand), 0);
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  // Counts edges from reset release until In_Ready is seen high.
  task automatic check_drain();
    int n;
    n = 0;
    while (n < 100) begin
      @(posedge Clk);
      #1;
      n++;
      if (In_Ready) break;
    end
    chk("drain_cycles", n, 20);
  endtask

  task automatic send_pair(input int a, input int b, input logic last);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    @(negedge Clk);
    In_Valid = 1'b1;
    In_A     = 8'(a);
    In_B     = 8'(b);
    In_Last  = last;
    while (!done) begin
      if (In_Ready) begin
        @(posedge Clk);
        done = 1'b1;
        hs_count++;
      end else begin
        n++;
        if (n > 200) begin
          chk("handshake_timeout", 1, 0);
          break;
        end
        @(negedge Clk);
      end
    end
    #1;
    In_Valid = 1'b0;
  endtask

  // Reference: plain integer dot product with range-checked wrap or clamp.
  task automatic push_expected();
    exp_t e;
    longint acc;
    bit ov;
    acc = 0;
    ov  = 1'b0;
    foreach (pkt[i]) begin
      acc = acc + longint'(pkt[i].a) * longint'(pkt[i].b);
      if (acc > MaxV || acc < MinV) begin
        ov = 1'b1;
`ifdef BOOTH_MAC_SAT_EN
        acc = (acc > MaxV) ? MaxV : MinV;
`else
        acc = (acc > MaxV) ? acc - Span : acc + Span;
`endif
      end
    end
    e.acc = acc;
    e.ovf = ov;
    exp_q.push_back(e);
  endtask

  task automatic run_packet(input int gap_max);
    push_expected();
    foreach (pkt[i]) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge Clk);
      send_pair(pkt[i].a, pkt[i].b, i == pkt.size() - 1);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge Clk);
      n++;
    end
    chk("result_timeout", longint'(exp_q.size()), 0);
    repeat (2) @(posedge Clk);
  endtask

  task automatic add_pair(input int a, input int b);
    pair_t p;
    p.a = a;
    p.b = b;
    pkt.push_back(p);
  endtask

  initial begin
    int st0;
    int len;
    checks   = 0;
    failures = 0;
    hs_count = 0;
    Rst      = 1'b1;
    In_Valid = 1'b0;
    In_A     = '0;
    In_B     = '0;
    In_Last  = 1'b0;

    do_reset();
    // Hold a valid pair through DRAIN; it must not be taken early.
    In_Valid = 1'b1;
    In_A     = 8'd3;
    In_B     = 8'd4;
    In_Last  = 1'b1;
    check_drain();

    st0 = hs_count;
    pkt.delete();
    add_pair(3, 4);
    run_packet(0);
    wait_empty();
    chk("single_pair_st_pulses", st_pulses - st0, 1);

    pkt.delete();
    add_pair(-128, -128);
    add_pair(5, -7);
    add_pair(-1, 1);
    run_packet(2);
    wait_empty();

    // Done is still high from the last product here.
    pkt.delete();
    add_pair(2, 2);
    run_packet(0);
    wait_empty();

    pkt.delete();
    for (int i = 0; i < 512; i++) add_pair(-128, -128);
    run_packet(0);
    wait_empty();
    chk("ovf_held_after_packet", longint'(Ovf), 1);

    pkt.delete();
    add_pair(1, 1);
    run_packet(0);
    wait_empty();

    // Abort mid-packet: second pair of three is in WAIT_DONE when Rst hits.
    send_pair(10, 10, 1'b0);
    send_pair(20, 20, 1'b0);
    repeat (4) @(posedge Clk);
    do_reset();
    check_drain();
    pkt.delete();
    add_pair(2, 3);
    run_packet(0);
    wait_empty();

    for (int k = 0; k < 25; k++) begin
      pkt.delete();
      len = int'($urandom_range(5, 1));
      for (int i = 0; i < len; i++) begin
        add_pair(int'($urandom_range(255, 0)) - 128, int'($urandom_range(255, 0)) - 128);
      end
      run_packet(3);
      wait_empty();
    end

    chk("st_pulses_vs_handshakes", st_pulses, hs_count);
    chk("mcand_stable", mcand_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
